mem_resp_model: RTL

MEM_RESP_MODEL -- requirements
Module: mem_resp_model

---
 rtl/mem_resp_model.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_resp_model.sv
// Fixed-latency memory responder: accepts one request at a time and answers latency_p cycles later.
// Optional MEM_RESP_RANGE_ERR_EN flags out-of-range indices on mem_err_o instead of wrapping.
module mem_resp_model #(
  parameter int els_p            = 32768,
  parameter int dma_data_width_p = 16,
  parameter int latency_p        = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        mem_valid_i,
  output logic                        mem_ready_o,
  input  logic                        mem_we_i,
  input  logic [31:0]                 mem_addr_i,
  input  logic [dma_data_width_p-1:0] mem_wdata_i,
  output logic                        mem_valid_o,
  output logic [dma_data_width_p-1:0] mem_data_o
`ifdef MEM_RESP_RANGE_ERR_EN
  ,
  output logic                        mem_err_o
`endif
);

  localparam int BYTE_SHIFT = $clog2(dma_data_width_p / 8);
  localparam int IDX_W      = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int CNT_W      = (latency_p > 2) ? $clog2(latency_p - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((latency_p > 1) ? latency_p - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                      state_q, state_n;
  logic [CNT_W-1:0]            cnt_q, cnt_n;
  logic                        we_q;
  logic [IDX_W-1:0]            idx_q;
  logic [dma_data_width_p-1:0] wdata_q;
  logic [dma_data_width_p-1:0] data_q, data_n;
  logic [dma_data_width_p-1:0] mem [els_p];

  logic [31:0]      shifted;
  logic [IDX_W-1:0] idx_n;
  logic             accept;
  logic             in_resp;
  logic             commit;

  assign shifted = mem_addr_i >> BYTE_SHIFT;
  assign idx_n   = (els_p > 1) ? shifted[IDX_W-1:0] : '0;
  assign in_resp = (state_q == RESP);

  // Reset masks the handshake outputs combinationally so nothing leaks while reset is held.
  assign mem_ready_o = (state_q == IDLE) && !reset_i;
  assign mem_valid_o = in_resp && !reset_i;
  assign accept      = mem_valid_i && mem_ready_o;

`ifdef MEM_RESP_RANGE_ERR_EN
  logic oor_q;
  assign commit    = in_resp && we_q && !oor_q && !reset_i;
  assign mem_err_o = in_resp && oor_q && !reset_i;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^(shifted >> IDX_W);
  assign commit = in_resp && we_q && !reset_i;
`endif

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (latency_p == 1) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_n = RESP;
        else             cnt_n   = cnt_q - 1'b1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // data_n is what the bus sees this cycle; data_q holds the last read result between reads.
  always_comb begin
    data_n = data_q;
    if (in_resp && !we_q) data_n = mem[idx_q];
`ifdef MEM_RESP_RANGE_ERR_EN
    if (in_resp && oor_q) data_n = '0;
`endif
  end

  assign mem_data_o = reset_i ? '0 : data_n;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (in_resp && !we_q) data_q <= data_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= mem_we_i;
      idx_q   <= idx_n;
      wdata_q <= mem_wdata_i;
`ifdef MEM_RESP_RANGE_ERR_EN
      oor_q   <= (shifted >= 32'(els_p));
`endif
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (commit) mem[idx_q] <= wdata_q;
  end

endmodule
